timekeeper_param: RTL and testbench

TIMEKEEPER_PARAM -- requirements
Module: timekeeper_param

---
 rtl/timekeeper_pkg.sv | 26 ++
 rtl/tick_gen.sv | 40 ++++
 rtl/timekeeper_param.sv | 118 +++++++++++
 tb/tb_timekeeper_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// Shared encodings, field limits and the binary-to-BCD helper for the timekeeper.
package timekeeper_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_SEC  = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_HR   = 2'b11;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Two-digit conversion; inputs never exceed 59.
  function automatic bcd2_t bin2bcd(input logic [5:0] v);
    bcd2_t r;
    r.tens = 4'(v / 6'd10);
    r.ones = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clkinput,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("tick_gen: DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  // Gated by reset so the pulse is low whenever reset is held.
  assign tick = en & ~reset & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clkinput) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timekeeper_param.sv
// Time-of-day counter with manual setting, 12/24-hour BCD display and a minute alarm.
module timekeeper_param
  import timekeeper_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clkinput,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic       tick,
  output logic       alarm
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clkinput(clkinput),
    .reset   (reset),
    .en      (run),
    .tick    (tick)
  );

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (set_sel == SEL_NONE) begin
      if (tick) begin
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d = '0;
            hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end else if (set_inc) begin
      // Manual setting wraps the selected field only, no carry.
      unique case (set_sel)
        SEL_SEC: sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
        SEL_MIN: min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
        SEL_HR:  hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + 5'd1;
        default: ;
      endcase
    end
    // Only tick-driven advances can land on the alarm time.
    alarm_d = alarm_en & tick & (set_sel == SEL_NONE) & (sec_d == 6'd0) &
              (min_d == alarm_min) & (hr_d == alarm_hr);
  end

  always_ff @(posedge clkinput) begin
    if (reset) begin
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      alarm_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

  logic [4:0] hr_disp;
  bcd2_t      sec_bcd, min_bcd, hr_bcd;

  always_comb begin
    hr_disp = hr_q;
    if (mode_12h) begin
      if (hr_q == 5'd0) begin
        hr_disp = 5'd12;
      end else if (hr_q > 5'd12) begin
        hr_disp = hr_q - 5'd12;
      end
    end
  end

  assign sec_bcd  = bin2bcd(sec_q);
  assign min_bcd  = bin2bcd(min_q);
  assign hr_bcd   = bin2bcd({1'b0, hr_disp});

  assign sec_ones = sec_bcd.ones;
  assign sec_tens = sec_bcd.tens;
  assign min_ones = min_bcd.ones;
  assign min_tens = min_bcd.tens;
  assign hr_ones  = hr_bcd.ones;
  assign hr_tens  = hr_bcd.tens;
  assign pm       = (hr_q >= 5'd12);

endmodule

// File: tb/tb_timekeeper_param.sv
// Scoreboard bench: a seconds-of-day reference model predicts each cycle's outputs.
module tb_timekeeper_param;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset, run, mode_12h, set_inc, alarm_en;
  logic [1:0] set_sel;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       pm, tick, alarm;

  always #5 clk = ~clk;

  timekeeper_param #(
    .CLK_HZ (10),
    .TICK_HZ(1)
  ) dut (
    .clkinput (clk),
    .reset    (reset),
    .run      (run),
    .mode_12h (mode_12h),
    .set_sel  (set_sel),
    .set_inc  (set_inc),
    .alarm_en (alarm_en),
    .alarm_hr (alarm_hr),
    .alarm_min(alarm_min),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .hr_ones  (hr_ones),
    .hr_tens  (hr_tens),
    .pm       (pm),
    .tick     (tick),
    .alarm    (alarm)
  );

  typedef struct {
    logic [23:0] digits;
    logic        pm;
    logic        tick;
    logic        alarm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: time as seconds since midnight, prescaler phase, pending alarm.
  int   m_t, m_p;
  bit   m_alarm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] disp(input int t, input bit m12);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    if (m12) h = (h % 12 == 0) ? 12 : h % 12;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int field(input logic [1:0] sel);
    case (sel)
      2'd1:    return m_t % 60;
      2'd2:    return (m_t / 60) % 60;
      default: return m_t / 3600;
    endcase
  endfunction

  task automatic model_update();
    bit tk;
    int h, m, s;
    if (reset) begin
      m_t = 0; m_p = 0; m_alarm = 0;
    end else begin
      tk = run && (m_p == DIV - 1);
      m_alarm = 0;
      if (run) m_p = (m_p + 1) % DIV;
      if (set_sel == 2'd0) begin
        if (tk) begin
          m_t = (m_t + 1) % 86400;
          if (alarm_en && alarm_hr < 24 && alarm_min < 60 &&
              m_t == int'(alarm_hr) * 3600 + int'(alarm_min) * 60) m_alarm = 1;
        end
      end else if (set_inc) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        case (set_sel)
          2'd1:    s = (s + 1) % 60;
          2'd2:    m = (m + 1) % 60;
          default: h = (h + 1) % 24;
        endcase
        m_t = h * 3600 + m * 60 + s;
      end
    end
  endtask

  // Push the prediction for the current cycle, then advance DUT and model together.
  task automatic step();
    exp_t e;
    e.digits = disp(m_t, mode_12h);
    e.pm     = (m_t / 3600) >= 12;
    e.tick   = run && !reset && (m_p == DIV - 1);
    e.alarm  = m_alarm;
    sb_q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_to(input logic [1:0] sel, input int target);
    run = 0;
    set_sel = sel;
    for (int i = 0; i < 64 && field(sel) != target; i++) begin
      set_inc = 1;
      step();
    end
    set_inc = 0;
    set_sel = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic count_alarms(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (alarm === 1'b1) cnt++;
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("digits", {8'h0, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones},
            {8'h0, mon_e.digits});
      check("pm", {31'h0, pm}, {31'h0, mon_e.pm});
      check("tick", {31'h0, tick}, {31'h0, mon_e.tick});
      check("alarm", {31'h0, alarm}, {31'h0, mon_e.alarm});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1; run = 0; mode_12h = 0; set_sel = 2'd0; set_inc = 0;
    alarm_en = 0; alarm_hr = 5'd0; alarm_min = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    m_t = 0; m_p = 0; m_alarm = 0;

    // Reset display in both modes, then 10 ticks from release.
    step();
    mode_12h = 1;
    step();
    mode_12h = 0;
    reset = 0; run = 1;
    steps(100);

    // Roll over from 23:59:59.
    set_to(2'd3, 23); set_to(2'd2, 59); set_to(2'd1, 59);
    run = 1;
    steps(12);

    // 12-hour display of hour 0 and hour 13, toggling mode.
    do_reset();
    mode_12h = 1;
    steps(2);
    set_to(2'd3, 13);
    steps(2);
    mode_12h = 0;
    steps(2);
    mode_12h = 1;
    steps(2);
    mode_12h = 0;

    // Minute wrap without carry; ticks while setting do not advance time.
    set_to(2'd3, 7); set_to(2'd1, 33); set_to(2'd2, 59);
    set_sel = 2'd2; set_inc = 1;
    step();
    set_inc = 0; run = 1;
    steps(25);
    set_sel = 2'd0; set_inc = 1;
    steps(3);
    set_inc = 0;

    // Alarm at 00:01 from 00:00:58, enabled then disabled.
    do_reset();
    alarm_en = 1; alarm_hr = 5'd0; alarm_min = 6'd1;
    set_to(2'd1, 58);
    run = 1;
    count_alarms(40, cnt);
    check("alarm_count_enabled", cnt, 1);
    do_reset();
    alarm_en = 0;
    set_to(2'd1, 58);
    run = 1;
    count_alarms(40, cnt);
    check("alarm_count_disabled", cnt, 0);

    // Reset mid-count at prescaler 7, then freeze with run=0.
    do_reset();
    set_to(2'd3, 5); set_to(2'd2, 30); set_to(2'd1, 12);
    run = 1;
    for (int i = 0; i < 20 && m_p != 7; i++) step();
    do_reset();
    run = 0;
    steps(15);
    run = 1;
    steps(25);

    // Randomized phase with occasional alarm targets near the current time.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      run      = ($urandom_range(0, 9) != 0);
      set_sel  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      set_inc  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      if (i % 100 == 0) begin
        alarm_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) begin
          alarm_hr  = 5'($urandom_range(0, 31));
          alarm_min = 6'($urandom_range(0, 63));
        end else begin
          alarm_hr  = 5'(((m_t + 60) % 86400) / 3600);
          alarm_min = 6'((((m_t + 60) % 86400) / 60) % 60);
        end
      end
      step();
    end
    reset = 0; set_inc = 0; set_sel = 2'd0;

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
